mem_access_ctrl: RTL and testbench

MEM_ACCESS_CTRL -- requirements
Module: mem_access_ctrl

---
 rtl/mem_access_ctrl_pkg.sv | 12 +
 rtl/mem_access_ctrl_load_extend.sv | 18 +
 rtl/mem_access_ctrl.sv | 86 ++++++++
 tb/tb_mem_access_ctrl.sv | 134 +++++++++++++
 4 files changed

// File: rtl/mem_access_ctrl_pkg.sv
// common: shared bus types and access-size helpers for the memory stage
package common;
  typedef logic [63:0] u64;
  typedef logic [7:0] strobe_t;
  typedef enum logic [1:0] {MSIZE1, MSIZE2, MSIZE4, MSIZE8} msize_t;
  function automatic strobe_t size_mask(msize_t m);
    return m == MSIZE1 ? 8'h01 : m == MSIZE2 ? 8'h03 : m == MSIZE4 ? 8'h0F : 8'hFF;
  endfunction
  function automatic logic misaligned(msize_t m, logic [2:0] a);
    return m == MSIZE2 ? a[0] : m == MSIZE4 ? |a[1:0] : m == MSIZE8 ? |a : 1'b0;
  endfunction
endpackage

// File: rtl/mem_access_ctrl_load_extend.sv
// mem_load_extend: picks the addressed lane out of a raw read word and extends it to 64 bits
module mem_load_extend
  import common::*;
(
  input  logic [2:0] lane,
  input  msize_t     msize,
  input  logic       is_unsigned,
  input  u64         raw,
  output u64         y
);
  u64 sh;
  logic sg;
  assign sh = raw >> {lane, 3'b000};
  assign sg = ~is_unsigned & (msize == MSIZE1 ? sh[7] : msize == MSIZE2 ? sh[15] : sh[31]);
  assign y = msize == MSIZE1 ? {{56{sg}}, sh[7:0]} :
             msize == MSIZE2 ? {{48{sg}}, sh[15:0]} :
             msize == MSIZE4 ? {{32{sg}}, sh[31:0]} : sh;
endmodule

// File: rtl/mem_access_ctrl.sv
// mem_access_ctrl: memory-stage load/store sequencer driving a request/response data bus
module mem_access_ctrl
  import common::*;
(
  input  logic    clk,
  input  logic    reset,
  input  logic    req_valid,
  input  logic    req_store,
  input  u64      req_addr,
  input  u64      req_data,
  input  msize_t  req_msize,
  input  logic    req_unsigned,
  output logic    dreq_valid,
  output u64      dreq_addr,
  output msize_t  dreq_size,
  output strobe_t dreq_strobe,
  output u64      dreq_data,
  input  logic    dresp_addr_ok,
  input  logic    dresp_data_ok,
  input  u64      dresp_data,
  output logic    busy,
  output logic    done,
  output u64      rdata,
  output logic    misalign
);
  typedef enum logic [1:0] {IDLE, REQ, WAIT, RESP} state_t;
  state_t state, state_n;
  logic st_q, uns_q, mis;
  u64 shifted, st_data, ext;
  strobe_t st_strb;
  assign mis = misaligned(req_msize, req_addr[2:0]);
  assign shifted = req_data << {req_addr[2:0], 3'b000};
  assign st_strb = req_store ? size_mask(req_msize) << req_addr[2:0] : '0;
  always_comb begin
    st_data = '0;
    for (int i = 0; i < 8; i++) st_data[8*i+:8] = st_strb[i] ? shifted[8*i+:8] : 8'h00;
  end
  always_comb begin
    state_n = state;
    case (state)
      IDLE: if (req_valid) state_n = mis ? RESP : REQ;
      REQ: if (dresp_addr_ok) state_n = dresp_data_ok ? RESP : WAIT;
      WAIT: if (dresp_data_ok) state_n = RESP;
      default: state_n = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else state <= state_n;
  end
  // bus fields are captured once in IDLE so they stay stable while REQ waits for addr_ok
  always_ff @(posedge clk) begin
    if (reset) begin
      dreq_addr <= '0;
      dreq_size <= MSIZE1;
      dreq_strobe <= '0;
      dreq_data <= '0;
      st_q <= 1'b0;
      uns_q <= 1'b0;
      misalign <= 1'b0;
      rdata <= '0;
    end else begin
      if (state == IDLE && req_valid) begin
        dreq_addr <= req_addr;
        dreq_size <= req_msize;
        dreq_strobe <= mis ? '0 : st_strb;
        dreq_data <= mis ? '0 : st_data;
        st_q <= req_store;
        uns_q <= req_unsigned;
        misalign <= mis;
        rdata <= '0;
      end
      if ((state == REQ || state == WAIT) && state_n == RESP) rdata <= st_q ? '0 : ext;
    end
  end
  mem_load_extend u_ext (
    .lane(dreq_addr[2:0]),
    .msize(dreq_size),
    .is_unsigned(uns_q),
    .raw(dresp_data),
    .y(ext)
  );
  assign dreq_valid = state == REQ;
  assign busy = state != IDLE;
  assign done = state == RESP;
endmodule

// File: tb/tb_mem_access_ctrl.sv
// tb_mem_access_ctrl: directed load/store vectors with a queue-based scoreboard on bus and completion
module tb_mem_access_ctrl;
  import common::*;
  logic clk = 0, reset = 1, req_valid = 0, req_store = 0, req_unsigned = 0;
  u64 req_addr = 0, req_data = 0, dreq_addr, dreq_data, dresp_data = 0, rdata;
  msize_t req_msize = MSIZE1, dreq_size;
  strobe_t dreq_strobe;
  logic dreq_valid, dresp_addr_ok = 0, dresp_data_ok = 0, busy, done, misalign;
  int checks = 0, errors = 0;
  typedef struct {u64 addr; msize_t size; strobe_t strb; u64 data;} dexp_t;
  typedef struct {u64 rd; logic mis;} rexp_t;
  dexp_t dq[$];
  rexp_t rq[$];

  mem_access_ctrl dut (
    .clk(clk), .reset(reset), .req_valid(req_valid), .req_store(req_store),
    .req_addr(req_addr), .req_data(req_data), .req_msize(req_msize),
    .req_unsigned(req_unsigned), .dreq_valid(dreq_valid), .dreq_addr(dreq_addr),
    .dreq_size(dreq_size), .dreq_strobe(dreq_strobe), .dreq_data(dreq_data),
    .dresp_addr_ok(dresp_addr_ok), .dresp_data_ok(dresp_data_ok), .dresp_data(dresp_data),
    .busy(busy), .done(done), .rdata(rdata), .misalign(misalign)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (!reset) begin
      if (dreq_valid) begin
        chk("dreq_expected", 64'(dq.size() > 0), 64'd1);
        if (dq.size() > 0) begin
          chk("dreq_addr", dreq_addr, dq[0].addr);
          chk("dreq_size", 64'(dreq_size), 64'(dq[0].size));
          chk("dreq_strobe", 64'(dreq_strobe), 64'(dq[0].strb));
          chk("dreq_data", dreq_data, dq[0].data);
          if (dresp_addr_ok) void'(dq.pop_front());
        end
      end
      if (done) begin
        chk("done_expected", 64'(rq.size() > 0), 64'd1);
        if (rq.size() > 0) begin
          chk("rdata", rdata, rq[0].rd);
          chk("misalign", 64'(misalign), 64'(rq[0].mis));
          void'(rq.pop_front());
        end
      end
    end
  end

  task automatic access(input string nm, input bit st, input u64 a, input u64 d, input msize_t m,
                        input bit u, input int aok, input int dok, input u64 rw, input u64 exp_r,
                        input bit exp_m, input strobe_t exp_s, input u64 exp_d, input int exp_cyc);
    int n = 0, rc = 0, w = -1;
    bit got = 0;
    if (!exp_m) dq.push_back('{a, m, exp_s, exp_d});
    rq.push_back('{exp_r, exp_m});
    req_valid = 1; req_store = st; req_addr = a; req_data = d; req_msize = m; req_unsigned = u;
    while (n < 60 && !got) begin
      dresp_addr_ok = 0; dresp_data_ok = 0; dresp_data = 0;
      if (dreq_valid) begin
        if (rc == aok) begin
          dresp_addr_ok = 1;
          if (dok == 0) begin dresp_data_ok = 1; dresp_data = rw; end
          else w = dok;
        end
        rc++;
      end else if (w > 0) begin
        w--;
        if (w == 0) begin dresp_data_ok = 1; dresp_data = rw; end
      end
      @(posedge clk); #1; n++;
      if (done) got = 1;
    end
    req_valid = 0; dresp_addr_ok = 0; dresp_data_ok = 0; dresp_data = 0;
    chk({nm, "_latency"}, got ? 64'(n + 1) : '1, 64'(exp_cyc));
    @(posedge clk); #1;
    chk({nm, "_single_done"}, 64'(done), 64'd0);
    chk({nm, "_idle_after"}, 64'(busy), 64'd0);
  endtask

  initial begin
    repeat (2) @(posedge clk);
    #1;
    chk("rst_busy", 64'(busy), 0);
    chk("rst_done", 64'(done), 0);
    chk("rst_dreq_valid", 64'(dreq_valid), 0);
    chk("rst_misalign", 64'(misalign), 0);
    chk("rst_rdata", rdata, 0);
    chk("rst_strobe", 64'(dreq_strobe), 0);
    chk("rst_dreq_data", dreq_data, 0);
    reset = 0;
    @(posedge clk); #1;
    access("sb", 1, 64'h1005, 64'hAB, MSIZE1, 0, 0, 0, 0, 0, 0, 8'h20, 64'h0000AB0000000000, 3);
    access("lh", 0, 64'h2006, 0, MSIZE2, 0, 0, 2, 64'h8001000000000000, 64'hFFFFFFFFFFFF8001, 0, 8'h00, 0, 5);
    access("lw_mis", 0, 64'h3002, 0, MSIZE4, 0, 0, 0, 0, 0, 1, 8'h00, 0, 2);
    access("sd", 1, 64'h4008, 64'h1122334455667788, MSIZE8, 0, 4, 0, 0, 0, 0, 8'hFF, 64'h1122334455667788, 7);
    // abandon a load while WAIT-ing on data_ok
    dq.push_back('{64'hE000, MSIZE4, 8'h00, 64'h0});
    req_valid = 1; req_store = 0; req_addr = 64'hE000; req_msize = MSIZE4; req_unsigned = 0;
    @(posedge clk); #1;
    dresp_addr_ok = 1;
    @(posedge clk); #1;
    dresp_addr_ok = 0;
    chk("wait_busy", 64'(busy), 1);
    chk("wait_no_dreq", 64'(dreq_valid), 0);
    reset = 1; req_valid = 0;
    @(posedge clk); #1;
    chk("rst_wait_busy", 64'(busy), 0);
    chk("rst_wait_done", 64'(done), 0);
    reset = 0;
    @(posedge clk); #1;
    chk("post_rst_done", 64'(done), 0);
    access("lbu", 0, 64'h5007, 0, MSIZE1, 1, 0, 0, 64'hFF00000000000000, 64'hFF, 0, 8'h00, 0, 3);
    access("lw", 0, 64'h6004, 0, MSIZE4, 0, 1, 1, 64'h8765432100000000, 64'hFFFFFFFF87654321, 0, 8'h00, 0, 5);
    access("ld", 0, 64'h7000, 0, MSIZE8, 1, 0, 1, 64'hDEADBEEFCAFEF00D, 64'hDEADBEEFCAFEF00D, 0, 8'h00, 0, 4);
    access("sh", 1, 64'h8002, 64'hFFFFBEEF, MSIZE2, 0, 0, 0, 0, 0, 0, 8'h0C, 64'h00000000BEEF0000, 3);
    access("lb", 0, 64'h9003, 0, MSIZE1, 0, 0, 0, 64'h000000007F000000, 64'h7F, 0, 8'h00, 0, 3);
    access("lhu", 0, 64'hA006, 0, MSIZE2, 1, 2, 0, 64'h8001000000000000, 64'h8001, 0, 8'h00, 0, 5);
    access("sh_mis", 1, 64'hB001, 64'h1234, MSIZE2, 0, 0, 0, 0, 0, 1, 8'h00, 0, 2);
    access("sd_mis", 1, 64'hC004, 64'h1234, MSIZE8, 0, 0, 0, 0, 0, 1, 8'h00, 0, 2);
    access("sb_l7", 1, 64'hD007, 64'h5A, MSIZE1, 0, 0, 0, 0, 0, 0, 8'h80, 64'h5A00000000000000, 3);
    chk("dq_drained", 64'(dq.size()), 0);
    chk("rq_drained", 64'(rq.size()), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
